// File: rtl/line_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : line_window_buffer_if
// Purpose  : Pixel-in / window-out bundle for line_window_buffer.
//            master = pixel source + window consumer, slave = the buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface line_window_buffer_if #(
  parameter int PIX_W = 8,
  parameter int WIN   = 3,
  parameter int CW    = 10
);
  logic                     in_valid;
  logic                     in_sof;
  logic [PIX_W-1:0]         in_data;
  logic                     out_valid;
  logic [WIN*WIN*PIX_W-1:0] window;
  logic [CW-1:0]            out_col;
  logic                     out_row_full;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, window, out_col, out_row_full
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, window, out_col, out_row_full
  );
endinterface
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_window_buffer
// Purpose  : Sliding WIN x WIN window line buffer. Keeps WIN-1 line delays of
//            COLS pixels plus WIN column taps per row. All outputs registered.
//            Optional feature macro: LINE_WINDOW_ZERO_PAD_EN (window emitted
//            for every pixel, taps outside the frame forced to zero).
// Revision : 1.0 - initial release
// ============================================================================
module line_window_buffer #(
  parameter int COLS  = 640,
  parameter int PIX_W = 8,
  parameter int WIN   = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  line_window_buffer_if.slave  bus
);
  localparam int             CW       = $clog2(COLS);
  localparam int             RW       = $clog2(WIN);
  localparam logic [CW-1:0]  LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0]  FULL_ROW = RW'(WIN - 1);

  // Line delays behave as a shift chain of exactly COLS accepted pixels: a
  // free-running ring pointer is used instead of the column counter, so a
  // frame resync never disturbs the vertical history.
  logic [PIX_W-1:0] line_mem [0:WIN-2][0:COLS-1];
  logic [PIX_W-1:0] line_rd  [0:WIN-2];
  logic [PIX_W-1:0] head     [0:WIN-1];
  logic [PIX_W-1:0] taps     [0:WIN-1][0:WIN-1];
  logic [CW-1:0]    ring_ptr;
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_fill;

  logic             accept;
  logic [CW-1:0]    pix_col;
  logic [RW-1:0]    pix_row;

  logic             valid_q;
  logic [CW-1:0]    col_q;
  logic             row_full_q;

  // Position of the pixel being accepted; in_sof forces it to (0,0).
  always_comb begin
    accept  = bus.in_valid;
    pix_col = bus.in_sof ? '0 : col_cnt;
    pix_row = bus.in_sof ? '0 : row_fill;
  end

  // Read-before-write taps of each line delay.
  for (genvar k = 0; k < WIN - 1; k++) begin : g_line_rd
    assign line_rd[k] = line_mem[k][ring_ptr];
  end

  // Newest pixel entering each window row: the live pixel for row 0,
  // the output of the previous line delay for deeper rows.
  always_comb begin
    head[0] = bus.in_data;
    for (int r = 1; r < WIN; r++) begin
      head[r] = line_rd[r-1];
    end
  end

  // Line storage write; contents deliberately not reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      line_mem[0][ring_ptr] <= bus.in_data;
      for (int k = 1; k < WIN - 1; k++) begin
        line_mem[k][ring_ptr] <= line_rd[k-1];
      end
    end
  end

  // Column taps: shift each row right by one on every accepted pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          taps[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < WIN; r++) begin
        taps[r][0] <= head[r];
        for (int c = 1; c < WIN; c++) begin
          taps[r][c] <= taps[r][c-1];
        end
      end
    end
  end

  // Ring pointer, column counter, row-fill counter and registered status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ring_ptr   <= '0;
      col_cnt    <= '0;
      row_fill   <= '0;
      valid_q    <= 1'b0;
      col_q      <= '0;
      row_full_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
`ifdef LINE_WINDOW_ZERO_PAD_EN
        valid_q <= 1'b1;
`else
        valid_q <= (pix_row == FULL_ROW) && (pix_col >= CW'(WIN - 1));
`endif
        col_q      <= pix_col;
        row_full_q <= (pix_row == FULL_ROW);
        ring_ptr   <= (ring_ptr == LAST_COL) ? '0 : ring_ptr + 1'b1;
        if (pix_col == LAST_COL) begin
          col_cnt  <= '0;
          row_fill <= (pix_row == FULL_ROW) ? pix_row : pix_row + 1'b1;
        end else begin
          col_cnt  <= pix_col + 1'b1;
          row_fill <= pix_row;
        end
      end
    end
  end

`ifdef LINE_WINDOW_ZERO_PAD_EN
  logic [WIN*WIN*PIX_W-1:0] window_q;

  // Masked copy of the next tap values: taps above the frame top or left of
  // column 0 (including wrap from the previous line) read as zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      window_q <= '0;
    end else if (accept) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          if ((RW'(r) > pix_row) || (CW'(c) > pix_col)) begin
            window_q[((r*WIN)+c)*PIX_W +: PIX_W] <= '0;
          end else if (c == 0) begin
            window_q[((r*WIN)+c)*PIX_W +: PIX_W] <= head[r];
          end else begin
            window_q[((r*WIN)+c)*PIX_W +: PIX_W] <= taps[r][c-1];
          end
        end
      end
    end
  end

  assign bus.window = window_q;
`else
  logic [WIN*WIN*PIX_W-1:0] window_flat;

  // Taps are already registered; just pack them row-major, newest first.
  always_comb begin
    window_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        window_flat[((r*WIN)+c)*PIX_W +: PIX_W] = taps[r][c];
      end
    end
  end

  assign bus.window = window_flat;
`endif

  assign bus.out_valid    = valid_q;
  assign bus.out_col      = col_q;
  assign bus.out_row_full = row_full_q;

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_buffer
// Purpose  : Self-checking bench for line_window_buffer (COLS=8, WIN=3).
//            Reference model: history of accepted pixels since reset plus
//            frame position; tap (r,c) is the pixel r*COLS+c accepts ago.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_window_buffer;
  localparam int COLS  = 8;
  localparam int PIX_W = 8;
  localparam int WIN   = 3;
  localparam int CW    = $clog2(COLS);
  localparam int WW    = WIN*WIN*PIX_W;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  line_window_buffer_if #(.PIX_W(PIX_W), .WIN(WIN), .CW(CW)) bus();

  line_window_buffer #(.COLS(COLS), .PIX_W(PIX_W), .WIN(WIN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [PIX_W-1:0] hist[$];
  int               m_col = 0;
  int               m_row = 0;
  int               cur_col = 0;
  int               cur_row = 0;
  logic             e_valid = 1'b0;
  logic [CW-1:0]    e_col = '0;
  logic             e_row_full = 1'b0;

  task automatic check_value(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] tap(input int r, input int c);
    logic [WW-1:0] w;
    w = bus.window;
    return w[((r*WIN)+c)*PIX_W +: PIX_W];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_col = 0; m_row = 0; cur_col = 0; cur_row = 0;
    e_valid = 1'b0; e_col = '0; e_row_full = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic sof, input logic [PIX_W-1:0] d);
    int pc, pr;
    if (!v) begin
      e_valid = 1'b0;
      return;
    end
    pc = sof ? 0 : m_col;
    pr = sof ? 0 : m_row;
    hist.push_front(d);
    if (hist.size() > 32) void'(hist.pop_back());
    cur_col = pc; cur_row = pr;
`ifdef LINE_WINDOW_ZERO_PAD_EN
    e_valid = 1'b1;
`else
    e_valid = (pr == WIN-1) && (pc >= WIN-1);
`endif
    e_col      = CW'(pc);
    e_row_full = (pr == WIN-1);
    if (pc == COLS-1) begin
      m_col = 0;
      m_row = (pr < WIN-1) ? pr + 1 : pr;
    end else begin
      m_col = pc + 1;
      m_row = pr;
    end
  endtask

  task automatic compare_all();
    logic [WW-1:0] exp_w, mask;
    exp_w = '0; mask = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
`ifdef LINE_WINDOW_ZERO_PAD_EN
        if (r > cur_row || c > cur_col) begin
          mask[((r*WIN)+c)*PIX_W +: PIX_W] = '1;
          continue;
        end
`endif
        if (r*COLS + c < hist.size()) begin
          exp_w[((r*WIN)+c)*PIX_W +: PIX_W] = hist[r*COLS + c];
          mask[((r*WIN)+c)*PIX_W +: PIX_W]  = '1;
        end
      end
    end
    check_value("out_valid", WW'(bus.out_valid), WW'(e_valid));
    check_value("out_col", WW'(bus.out_col), WW'(e_col));
    check_value("out_row_full", WW'(bus.out_row_full), WW'(e_row_full));
    check_value("window", bus.window & mask, exp_w);
  endtask

  task automatic step(input logic v, input logic sof, input logic [PIX_W-1:0] d);
    @(negedge clock);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    @(posedge clock);
    #1;
    model_step(v, sof, d);
    compare_all();
  endtask

  // Rows 0..3 of the row*16+col stream, optionally idling after each pixel.
  task automatic run_stream(input bit idle_gaps);
    logic [PIX_W-1:0] d;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < COLS; col++) begin
        d = PIX_W'(row*16 + col);
        step(1'b1, (row == 0 && col == 0), d);
`ifdef LINE_WINDOW_ZERO_PAD_EN
        if (!idle_gaps && d == 8'h01) begin
          check_value("zp_01_c00", WW'(tap(0,0)), WW'(8'h01));
          check_value("zp_01_c01", WW'(tap(0,1)), WW'(8'h00));
          check_value("zp_01_other", WW'(bus.window) >> (2*PIX_W), '0);
        end
        if (!idle_gaps && d == 8'h10) begin
          check_value("zp_10_c00", WW'(tap(0,0)), WW'(8'h10));
          check_value("zp_10_c10", WW'(tap(1,0)), WW'(8'h00));
          check_value("zp_10_c01", WW'(tap(0,1)), WW'(8'h00));
        end
`else
        if (!idle_gaps && d == 8'h21) check_value("s1_pre_valid", WW'(bus.out_valid), WW'(1'b0));
        if (!idle_gaps && d == 8'h22) begin
          check_value("s1_valid", WW'(bus.out_valid), WW'(1'b1));
          check_value("s1_c00", WW'(tap(0,0)), WW'(8'h22));
          check_value("s1_c11", WW'(tap(1,1)), WW'(8'h11));
          check_value("s1_c22", WW'(tap(2,2)), WW'(8'h00));
          check_value("s1_col", WW'(bus.out_col), WW'(2));
        end
        if (!idle_gaps && d == 8'h23) check_value("s1_next_c00", WW'(tap(0,0)), WW'(8'h23));
        if (!idle_gaps && (d == 8'h30 || d == 8'h31)) check_value("s3_valid_lo", WW'(bus.out_valid), WW'(1'b0));
        if (!idle_gaps && d == 8'h32) begin
          check_value("s3_valid_hi", WW'(bus.out_valid), WW'(1'b1));
          check_value("s3_c20", WW'(tap(2,0)), WW'(8'h12));
        end
`endif
        if (idle_gaps) step(1'b0, 1'b0, PIX_W'($urandom));
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_value("rst_valid", WW'(bus.out_valid), '0);
    check_value("rst_window", bus.window, '0);
    check_value("rst_col", WW'(bus.out_col), '0);
    check_value("rst_row_full", WW'(bus.out_row_full), '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Scenarios 1/3: continuous stream, then scenario 2: idle gaps
    run_stream(1'b0);
    run_stream(1'b1);

    // Scenario 4: continue row 4 and resync at col 5, then three more lines
    for (int col = 0; col < 5; col++) step(1'b1, 1'b0, PIX_W'(8'h40 + col));
    step(1'b1, 1'b1, 8'h45);
    for (int i = 1; i < 3*COLS; i++) step(1'b1, 1'b0, PIX_W'($urandom));

    // Randomised traffic with sparse resyncs
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), PIX_W'($urandom));
    end

    // Scenario 5: asynchronous reset between edges, mid-line
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, PIX_W'($urandom));
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    model_reset();
    check_value("async_valid", WW'(bus.out_valid), '0);
    check_value("async_window", bus.window, '0);
    check_value("async_col", WW'(bus.out_col), '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_stream(1'b0);

    // Random tail after the rerun
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0), PIX_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
